// File: rtl/multiplier_seq_pkg.sv
// rtl/multiplier_seq_pkg.sv - shared constants and types for the sequential MULTU unit
//
// Purpose: default operand width, controller state encoding, and the MULTU
// funct code. The ALU control decode also uses MULTU to raise start.
// Ports: none (package).

package multiplier_seq_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [5:0] MULTU = 6'b011001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - radix-2 shift-add unsigned WIDTH x WIDTH multiplier
//
// Purpose: accepts two unsigned operands on start, iterates one shift-add
// step per cycle for WIDTH cycles, then presents the 2*WIDTH-bit product
// {Hi, Lo} together with a one-cycle done strobe.
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   request, honoured only in IDLE or DONE
//   dataA    in   multiplicand, sampled on accepted start
//   dataB    in   multiplier, sampled on accepted start
//   busy     out  high while iterating
//   done     out  one-cycle strobe, product valid
//   dataOut  out  product; [2W-1:W] = Hi, [W-1:0] = Lo; held until next completion

module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dataOut
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t         state_q;
    logic [WIDTH-1:0]   mcand_q;
    // Upper W+1 bits hold the running partial product (with carry); the
    // lower W bits start as the multiplier and are consumed LSB first.
    logic [2*WIDTH:0]   acc_q;
    logic [2*WIDTH:0]   acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] dataOut_q;

    logic [WIDTH:0]     sum;

    // One iteration: conditional add into the upper half, then logical shift.
    always_comb begin
        sum   = acc_q[2*WIDTH:WIDTH];
        acc_d = acc_q;
        if (acc_q[0]) begin
            sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        end
        acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dataOut_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        mcand_q <= dataA;
                        acc_q   <= {1'b0, {WIDTH{1'b0}}, dataB};
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Capture the post-step value so the last add is included.
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        dataOut_q <= acc_d[2*WIDTH-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dataOut = dataOut_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - self-checking bench for multiplier_seq

module tb_multiplier_seq;
    import multiplier_seq_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   dataA = '0;
    logic [W-1:0]   dataB = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] dataOut;

    int             vectors = 0;
    int             miscompares = 0;
    logic [2*W-1:0] last_prod = '0;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // Called at a falling edge; the next rising edge accepts the request.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        dataA = a;
        dataB = b;
    endtask

    // Follows an operation from acceptance to done, checking latency, busy
    // window, that the previous product is held, and the final product.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int repulse_at);
        logic [2*W-1:0] exp;
        int n;
        int busy_cnt;
        exp      = ref_mul(a, b);
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n <= W + 5) begin
            if (busy === 1'b1) busy_cnt++;
            if (n == 1 || n == W) check("hold_prev", dataOut, last_prod);
            if (n == repulse_at) begin
                start = 1'b1;
                dataA = ~a;
                dataB = b + 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", 64'(n), 64'(W + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(W));
        check("busy_at_done", 64'(busy), 64'd0);
        check("product", dataOut, exp);
        last_prod = exp;
    endtask

    task automatic expect_done_drop();
        @(negedge clk);
        check("done_strobe", 64'(done), 64'd0);
        check("held_after_done", dataOut, last_prod);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dataOut", dataOut, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        start_op(32'd3, 32'd5);
        run_op(32'd3, 32'd5, 0);
        check("const_3x5", dataOut, 64'h0000_0000_0000_000F);
        expect_done_drop();

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("const_max", dataOut, 64'hFFFF_FFFE_0000_0001);
        expect_done_drop();

        start_op(32'd0, 32'h1234_5678);
        run_op(32'd0, 32'h1234_5678, 0);
        check("const_zero", dataOut, 64'h0);
        expect_done_drop();

        start_op(32'h8000_0000, 32'd2);
        run_op(32'h8000_0000, 32'd2, 0);
        check("const_msb", dataOut, 64'h0000_0001_0000_0000);
        expect_done_drop();

        // start re-pulsed during RUN must not disturb the operation
        start_op(32'hDEAD_BEEF, 32'h0000_1001);
        run_op(32'hDEAD_BEEF, 32'h0000_1001, 10);
        expect_done_drop();

        // back-to-back: new request on the done cycle
        start_op(32'd9, 32'd11);
        run_op(32'd9, 32'd11, 0);
        start_op(32'd7, 32'd6);
        run_op(32'd7, 32'd6, 0);
        check("const_b2b", dataOut, 64'h2A);
        expect_done_drop();

        // asynchronous reset in the middle of RUN
        start_op(32'd5, 32'd9);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("async_busy", 64'(busy), 64'd0);
        check("async_done", 64'(done), 64'd0);
        check("async_dataOut", dataOut, 64'd0);
        last_prod = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        start_op(32'd2, 32'd2);
        run_op(32'd2, 32'd2, 0);
        check("const_2x2", dataOut, 64'h4);
        expect_done_drop();

        // randomized operands with mixed idle gaps, some back-to-back
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            start_op(ra, rb);
            run_op(ra, rb, (i % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0);
            if ($urandom_range(0, 1) == 0) begin
                expect_done_drop();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        expect_done_drop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
